// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: loadable internal memory, IDLE/FETCH/HALT control, valid/ready output
// with stall, redirect flush and out-of-range halt. Optional macro BRANCH_PREDECODE_EN adds direct-jump predecode.
module instr_fetch_unit #(
    parameter int ADDR_W    = 8,
    parameter int INSTR_W   = 8,
    parameter int MEM_DEPTH = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_prog_we,
    input  logic [ADDR_W-1:0]  i_prog_addr,
    input  logic [INSTR_W-1:0] i_prog_data,
    input  logic               i_run,
    input  logic               i_redirect_valid,
    input  logic [ADDR_W-1:0]  i_redirect_pc,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [INSTR_W-1:0] o_out_instr,
    output logic [ADDR_W-1:0]  o_out_pc,
    output logic [ADDR_W-1:0]  o_pc,
    output logic               o_halted,
    output logic [1:0]         o_fsm_state
);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    logic [INSTR_W-1:0] r_mem [MEM_DEPTH];

    state_t             r_state, w_state_nxt;
    logic [ADDR_W-1:0]  r_pc, w_pc_nxt;
    logic               r_out_valid, w_out_valid_nxt;
    logic [INSTR_W-1:0] r_out_instr, w_out_instr_nxt;
    logic [ADDR_W-1:0]  r_out_pc, w_out_pc_nxt;

    logic               w_pc_in_range;
    logic               w_prog_in_range;
    logic               w_slot_free;
    logic [INSTR_W-1:0] w_rd_data;
    logic [ADDR_W-1:0]  w_pc_inc;
    logic [ADDR_W-1:0]  w_next_pc;

    assign w_pc_in_range   = {1'b0, r_pc} < DEPTH;
    assign w_prog_in_range = {1'b0, i_prog_addr} < DEPTH;
    assign w_slot_free     = !r_out_valid || i_out_ready;
    assign w_rd_data       = r_mem[r_pc[IDX_W-1:0]];
    assign w_pc_inc        = r_pc + ADDR_W'(1);

`ifdef BRANCH_PREDECODE_EN
    // MSB marks a direct jump; the remaining bits are the absolute target.
    localparam int TW = (ADDR_W > INSTR_W-1) ? ADDR_W : INSTR_W-1;
    logic [TW-1:0] w_tgt_wide;
    assign w_tgt_wide = TW'(w_rd_data[INSTR_W-2:0]);
    assign w_next_pc  = w_rd_data[INSTR_W-1] ? w_tgt_wide[ADDR_W-1:0] : w_pc_inc;
`else
    assign w_next_pc  = w_pc_inc;
`endif

    // Memory has no reset so a loaded program survives a reset.
    always_ff @(posedge i_clk) begin
        if (i_reset && r_state == S_IDLE && i_prog_we && w_prog_in_range)
            r_mem[i_prog_addr[IDX_W-1:0]] <= i_prog_data;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_out_pc    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_instr <= w_out_instr_nxt;
            r_out_pc    <= w_out_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_out_valid_nxt = r_out_valid;
        w_out_instr_nxt = r_out_instr;
        w_out_pc_nxt    = r_out_pc;
        case (r_state)
            S_IDLE: begin
                w_out_valid_nxt = 1'b0;
                if (i_run) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (i_redirect_valid) begin
                    w_pc_nxt        = i_redirect_pc;
                    w_out_valid_nxt = 1'b0;
                end else if (w_slot_free) begin
                    if (w_pc_in_range) begin
                        w_out_instr_nxt = w_rd_data;
                        w_out_pc_nxt    = r_pc;
                        w_out_valid_nxt = 1'b1;
                        w_pc_nxt        = w_next_pc;
                    end else begin
                        w_out_valid_nxt = 1'b0;
                        w_state_nxt     = S_HALT;
                    end
                end
            end
            S_HALT: begin
                w_out_valid_nxt = 1'b0;
                if (i_redirect_valid) begin
                    w_pc_nxt    = i_redirect_pc;
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_out_valid_nxt = 1'b0;
            end
        endcase
    end

    assign o_out_valid = r_out_valid;
    assign o_out_instr = r_out_instr;
    assign o_out_pc    = r_out_pc;
    assign o_pc        = r_pc;
    assign o_halted    = (r_state == S_HALT);
    assign o_fsm_state = r_state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a 4-deep memory instance (halt/stall/redirect/reset)
// and a 2-bit-address instance where the pc wraps instead of halting.
module tb_instr_fetch_unit;
    logic       clk;
    logic       reset, prog_we, run, redir, rdy;
    logic [7:0] prog_addr, prog_data, redir_pc;
    logic       out_valid, halted;
    logic [7:0] out_instr, out_pc, pc;
    logic [1:0] st;

    logic       b_reset, b_prog_we, b_run, b_valid, b_halted;
    logic [1:0] b_prog_addr, b_out_pc, b_pc, b_st;
    logic [7:0] b_prog_data, b_instr;

    int chk_total = 0;
    int chk_pass  = 0;

    instr_fetch_unit #(.ADDR_W(8), .INSTR_W(8), .MEM_DEPTH(4), .RESET_PC(8'd0)) dut (
        .i_clk(clk), .i_reset(reset), .i_prog_we(prog_we), .i_prog_addr(prog_addr),
        .i_prog_data(prog_data), .i_run(run), .i_redirect_valid(redir), .i_redirect_pc(redir_pc),
        .o_out_valid(out_valid), .i_out_ready(rdy), .o_out_instr(out_instr), .o_out_pc(out_pc),
        .o_pc(pc), .o_halted(halted), .o_fsm_state(st));

    instr_fetch_unit #(.ADDR_W(2), .INSTR_W(8), .MEM_DEPTH(4), .RESET_PC(2'd0)) dut_wrap (
        .i_clk(clk), .i_reset(b_reset), .i_prog_we(b_prog_we), .i_prog_addr(b_prog_addr),
        .i_prog_data(b_prog_data), .i_run(b_run), .i_redirect_valid(1'b0), .i_redirect_pc(2'd0),
        .o_out_valid(b_valid), .i_out_ready(1'b1), .o_out_instr(b_instr), .o_out_pc(b_out_pc),
        .o_pc(b_pc), .o_halted(b_halted), .o_fsm_state(b_st));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [7:0] a, input logic [7:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        step();
        prog_we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        chk_total++;
        if ({st, halted, out_valid, out_instr, out_pc, pc} !== {2'd0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00})
            $display("FAIL reset: st=%0d halt=%b v=%b instr=%h opc=%h pc=%h", st, halted, out_valid, out_instr, out_pc, pc);
        else chk_pass++;
        reset = 1'b1;
    endtask

    task automatic test_fetch_halt();
        logic [7:0] exp_instr [4];
        logic [7:0] exp_halt_pc;
        exp_instr[0] = 8'h19; exp_instr[1] = 8'h49; exp_instr[2] = 8'h0B; exp_instr[3] = 8'hC5;
`ifdef BRANCH_PREDECODE_EN
        exp_halt_pc = 8'h45;
`else
        exp_halt_pc = 8'h04;
`endif
        for (int i = 0; i < 4; i++) load_word(8'(i), exp_instr[i]);
        rdy = 1'b1; run = 1'b1;
        step();
        run = 1'b0;
        chk_total++;
        if ({st, out_valid, pc} !== {2'd1, 1'b0, 8'h00})
            $display("FAIL run_start: st=%0d v=%b pc=%h want st=1 v=0 pc=00", st, out_valid, pc);
        else chk_pass++;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_total++;
            if ({out_valid, out_instr, out_pc} !== {1'b1, exp_instr[i], 8'(i)})
                $display("FAIL fetch%0d: v=%b instr=%h opc=%h want 1 %h %h", i, out_valid, out_instr, out_pc, exp_instr[i], 8'(i));
            else chk_pass++;
        end
        chk_total++;
        if (pc !== exp_halt_pc)
            $display("FAIL jump_next_pc: pc=%h want %h", pc, exp_halt_pc);
        else chk_pass++;
        step();
        chk_total++;
        if ({st, halted, out_valid, pc} !== {2'd2, 1'b1, 1'b0, exp_halt_pc})
            $display("FAIL halt: st=%0d h=%b v=%b pc=%h want 2 1 0 %h", st, halted, out_valid, pc, exp_halt_pc);
        else chk_pass++;
    endtask

    task automatic test_halt_recovery();
        redir = 1'b1; redir_pc = 8'h01;
        step();
        redir = 1'b0;
        chk_total++;
        if ({st, halted, out_valid, pc} !== {2'd1, 1'b0, 1'b0, 8'h01})
            $display("FAIL halt_redirect: st=%0d h=%b v=%b pc=%h want 1 0 0 01", st, halted, out_valid, pc);
        else chk_pass++;
        step();
        chk_total++;
        if ({out_valid, out_instr, out_pc, pc} !== {1'b1, 8'h49, 8'h01, 8'h02})
            $display("FAIL halt_recover_fetch: v=%b instr=%h opc=%h pc=%h want 1 49 01 02", out_valid, out_instr, out_pc, pc);
        else chk_pass++;
    endtask

    task automatic test_stall();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_total++;
            if ({out_valid, out_instr, out_pc, pc} !== {1'b1, 8'h49, 8'h01, 8'h02})
                $display("FAIL stall%0d: v=%b instr=%h opc=%h pc=%h want 1 49 01 02", i, out_valid, out_instr, out_pc, pc);
            else chk_pass++;
        end
        rdy = 1'b1;
        step();
        chk_total++;
        if ({out_valid, out_instr, out_pc, pc} !== {1'b1, 8'h0B, 8'h02, 8'h03})
            $display("FAIL stall_release: v=%b instr=%h opc=%h pc=%h want 1 0b 02 03", out_valid, out_instr, out_pc, pc);
        else chk_pass++;
    endtask

    task automatic test_redirect_stalled();
        rdy = 1'b0;
        step();
        redir = 1'b1; redir_pc = 8'h00;
        step();
        redir = 1'b0;
        chk_total++;
        if ({st, out_valid, pc} !== {2'd1, 1'b0, 8'h00})
            $display("FAIL redirect_flush: st=%0d v=%b pc=%h want 1 0 00", st, out_valid, pc);
        else chk_pass++;
        rdy = 1'b1;
        step();
        chk_total++;
        if ({out_valid, out_instr, out_pc, pc} !== {1'b1, 8'h19, 8'h00, 8'h01})
            $display("FAIL redirect_fetch: v=%b instr=%h opc=%h pc=%h want 1 19 00 01", out_valid, out_instr, out_pc, pc);
        else chk_pass++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_instr [3];
        exp_instr[0] = 8'h19; exp_instr[1] = 8'h49; exp_instr[2] = 8'h0B;
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk_total++;
        if ({st, out_valid, out_instr, out_pc, pc} !== {2'd0, 1'b0, 8'h00, 8'h00, 8'h00})
            $display("FAIL reset_mid: st=%0d v=%b instr=%h opc=%h pc=%h want 0 0 00 00 00", st, out_valid, out_instr, out_pc, pc);
        else chk_pass++;
        redir = 1'b1; redir_pc = 8'h02;
        step();
        redir = 1'b0;
        chk_total++;
        if ({st, pc} !== {2'd0, 8'h00})
            $display("FAIL idle_redirect_ignored: st=%0d pc=%h want 0 00", st, pc);
        else chk_pass++;
        run = 1'b1;
        step();
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_total++;
            if ({out_valid, out_instr, out_pc} !== {1'b1, exp_instr[i], 8'(i)})
                $display("FAIL rerun%0d: v=%b instr=%h opc=%h want 1 %h %h", i, out_valid, out_instr, out_pc, exp_instr[i], 8'(i));
            else chk_pass++;
        end
    endtask

    task automatic test_prog_and_run();
        reset = 1'b0;
        step();
        reset = 1'b1;
        prog_we = 1'b1; prog_addr = 8'h00; prog_data = 8'h29; run = 1'b1;
        step();
        prog_we = 1'b0; run = 1'b0;
        chk_total++;
        if (st !== 2'd1)
            $display("FAIL prog_run_state: st=%0d want 1", st);
        else chk_pass++;
        step();
        chk_total++;
        if ({out_valid, out_instr, out_pc} !== {1'b1, 8'h29, 8'h00})
            $display("FAIL prog_run_fetch: v=%b instr=%h opc=%h want 1 29 00", out_valid, out_instr, out_pc);
        else chk_pass++;
        // Writes outside IDLE must not land.
        prog_we = 1'b1; prog_addr = 8'h01; prog_data = 8'hEE;
        step();
        prog_we = 1'b0;
        chk_total++;
        if ({out_instr, out_pc} !== {8'h49, 8'h01})
            $display("FAIL prog_ignored_in_fetch: instr=%h opc=%h want 49 01", out_instr, out_pc);
        else chk_pass++;
    endtask

    task automatic test_wrap();
        b_reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_prog_we = 1'b1; b_prog_addr = 2'(i); b_prog_data = 8'h11 + 8'(i);
            step();
        end
        b_prog_we = 1'b0; b_run = 1'b1;
        step();
        b_run = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk_total++;
            if ({b_valid, b_halted, b_instr, b_out_pc} !== {1'b1, 1'b0, 8'h11 + 8'(i % 4), 2'(i % 4)})
                $display("FAIL wrap%0d: v=%b h=%b instr=%h opc=%0d want 1 0 %h %0d", i, b_valid, b_halted, b_instr, b_out_pc, 8'h11 + 8'(i % 4), i % 4);
            else chk_pass++;
        end
    endtask

    initial begin
        reset = 1'b0; prog_we = 1'b0; run = 1'b0; redir = 1'b0; rdy = 1'b1;
        prog_addr = '0; prog_data = '0; redir_pc = '0;
        b_reset = 1'b0; b_prog_we = 1'b0; b_run = 1'b0; b_prog_addr = '0; b_prog_data = '0;
        step();
        test_reset();
        test_fetch_halt();
        test_halt_recovery();
        test_stall();
        test_redirect_stalled();
        test_reset_mid();
        test_prog_and_run();
        test_wrap();
        $display("%0d/%0d checks passed", chk_pass, chk_total);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Parametrised instruction fetch stage with an internal, loadable instruction memory.
- Supersedes the fixed 8-bit, 6-entry fetch block.
- Adds:
  - a program-load phase;
  - a valid/ready handshake toward decode, with stall support;
  - external PC redirect from execute;
  - an out-of-range halt.
- Sits between the program loader/testbench and the decode stage.

Parameters:
- ADDR_W, 8: PC and memory address width.
- INSTR_W, 8: instruction width.
- MEM_DEPTH, 64: number of instruction words; must satisfy 1 <= MEM_DEPTH <= 2**ADDR_W.
- RESET_PC, 0: PC value loaded at reset.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-low reset.
- prog_we, input, 1: memory write enable; honoured only in IDLE.
- prog_addr, input, ADDR_W: memory write address; ignored when >= MEM_DEPTH.
- prog_data, input, INSTR_W: memory write data.
- run, input, 1: start fetching; sampled only in IDLE.
- redirect_valid, input, 1: PC redirect request (jump or branch resolved downstream).
- redirect_pc, input, ADDR_W: redirect target.
- out_valid, output, 1: out_instr/out_pc hold a fetched instruction.
- out_ready, input, 1: decode accepts the output this cycle.
- out_instr, output, INSTR_W: fetched instruction.
- out_pc, output, ADDR_W: address of out_instr.
- pc, output, ADDR_W: next address to fetch.
- halted, output, 1: high while in HALT.
- fsm_state, output, 2: IDLE=0, FETCH=1, HALT=2.

Behaviour:
- Reset: when reset==0 at a rising edge:
  - pc=RESET_PC, state=IDLE;
  - out_valid=0, out_instr=0, out_pc=0, halted=0.
  - Memory contents are retained (not cleared).
- Reset asserted mid-operation aborts any pending output; no partial state survives.
- Memory:
  - Read is combinational (mem[pc]).
  - Write is synchronous, performed when prog_we=1 in IDLE.
- IDLE:
  - No fetch; out_valid=0.
  - run=1 -> FETCH next cycle.
  - prog_we and run in the same cycle: the write completes, then FETCH is entered.
- FETCH:
  - Output slot "free" = !out_valid || out_ready.
  - If the slot is free and pc < MEM_DEPTH:
    - out_instr<=mem[pc], out_pc<=pc, out_valid<=1;
    - pc<=next_pc, where next_pc = pc+1 modulo 2**ADDR_W.
  - If the slot is free and pc >= MEM_DEPTH:
    - out_valid<=0, state<=HALT, pc unchanged.
  - Slot not free (out_valid=1, out_ready=0): stall.
    - Output registers and pc are held stable.
- Latency: the instruction at address A appears on out_instr one cycle after pc==A with the slot free.
- Throughput: one instruction per cycle when out_ready is held high.
- Redirect (highest priority in FETCH and HALT):
  - redirect_valid=1 -> pc<=redirect_pc, out_valid<=0 (flush, even if stalled), state<=FETCH.
  - No fetch occurs in the redirect cycle.
- Redirect is ignored in IDLE.
- HALT:
  - out_valid=0, halted=1.
  - Leaves only on redirect (-> FETCH, halted<=0) or reset.
- pc wrap: when MEM_DEPTH==2**ADDR_W, pc wraps to 0 after the top address and never halts.

Optional Feature:
- Macro: BRANCH_PREDECODE_EN.
- Defined:
  - In FETCH, a fetched instruction with bit INSTR_W-1 == 1 is a direct jump.
  - next_pc = instr[INSTR_W-2:0], zero-extended or truncated to ADDR_W, instead of pc+1.
  - The jump instruction itself is still issued to decode.
  - redirect_valid still overrides it.
- Not defined: next_pc is always pc+1; jumps occur only via redirect.

Test Plan:
- Load 0x19,0x49,0x0B at addresses 0..2, pulse run, out_ready=1:
  - out_instr/out_pc sequence (0x19,0),(0x49,1),(0x0B,2) on consecutive cycles;
  - then halted=1 with pc=3 if MEM_DEPTH=3.
- Stall: hold out_ready=0 for 3 cycles while out_valid=1 showing (0x49,1):
  - out_instr, out_pc and pc stay 0x49, 1 and 2;
  - release -> next output is (0x0B,2).
- Redirect while stalled: redirect_valid=1, redirect_pc=0 while stalled:
  - next cycle out_valid=0, pc=0;
  - following cycle out_instr=0x19.
- Halt recovery: in HALT, redirect_pc=1 -> FETCH; out_instr=0x49 two cycles after the redirect.
- Reset mid-fetch: drive reset=0 one cycle:
  - pc=RESET_PC, out_valid=0, state IDLE;
  - rerun reproduces the same sequence (memory retained).
- BRANCH_PREDECODE_EN: program mem[3]=0xC5:
  - after issuing (0xC5,3) the next fetch is from address 0x45;
  - with the macro off, the next fetch is from address 4.
